// File: rtl/stft_frame_sequencer.sv
// STFT frame scheduler: writes samples into a circular RAM and, every HOP samples once
// primed, streams the latest FFT_SIZE samples oldest-first with window index and framing.
module stft_frame_sequencer #(
  parameter int unsigned FFT_SIZE = 512,
  parameter int unsigned HOP      = 128,
  parameter int unsigned AW       = 9,
  parameter int unsigned SW       = 25
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          start_compute,
  input  logic [SW-1:0] i_SAMPLE,
  input  logic          fft_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [SW-1:0] wr_data,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] win_addr,
  output logic          fft_in_valid,
  output logic          fft_in_last,
  output logic          frame_start,
  output logic          frame_dropped,
  output logic          busy,
  output logic [15:0]   frame_count
);

  localparam int unsigned FW = AW + 1;
  localparam int unsigned CW = 16;
  localparam logic [AW-1:0] LAST_K = AW'(FFT_SIZE - 1);
  localparam logic [AW-1:0] HOP_M1 = AW'(HOP - 1);
  localparam logic [FW-1:0] FULL   = FW'(FFT_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] hop_cnt_q, hop_cnt_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic          trig_q, trig_d;
  logic          accept;

  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [SW-1:0] wr_data_q, wr_data_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] win_addr_q, win_addr_d;
  logic          fft_in_valid_q, fft_in_valid_d;
  logic          fft_in_last_q, fft_in_last_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_dropped_q, frame_dropped_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] frame_count_q, frame_count_d;

  // State and output register; synchronous reset aborts any frame and forces re-priming.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      hop_cnt_q       <= '0;
      fill_cnt_q      <= '0;
      trig_q          <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      rd_en_q         <= 1'b0;
      rd_addr_q       <= '0;
      win_addr_q      <= '0;
      fft_in_valid_q  <= 1'b0;
      fft_in_last_q   <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_dropped_q <= 1'b0;
      busy_q          <= 1'b0;
      frame_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      hop_cnt_q       <= hop_cnt_d;
      fill_cnt_q      <= fill_cnt_d;
      trig_q          <= trig_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      rd_en_q         <= rd_en_d;
      rd_addr_q       <= rd_addr_d;
      win_addr_q      <= win_addr_d;
      fft_in_valid_q  <= fft_in_valid_d;
      fft_in_last_q   <= fft_in_last_d;
      frame_start_q   <= frame_start_d;
      frame_dropped_q <= frame_dropped_d;
      busy_q          <= busy_d;
      frame_count_q   <= frame_count_d;
    end
  end

  // Write path, priming and hop counting; trigger is registered so it lands one cycle after the pulse.
  always_comb begin
    wr_en_d    = start_compute;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_ptr_d   = wr_ptr_q;
    hop_cnt_d  = hop_cnt_q;
    fill_cnt_d = fill_cnt_q;
    trig_d     = 1'b0;
    if (start_compute) begin
      wr_addr_d = wr_ptr_q;
      wr_data_d = i_SAMPLE;
      wr_ptr_d  = wr_ptr_q + 1'b1;
      if (fill_cnt_q != FULL) fill_cnt_d = fill_cnt_q + 1'b1;
      if (hop_cnt_q == HOP_M1) begin
        hop_cnt_d = '0;
        trig_d    = (fill_cnt_d == FULL);
      end else begin
        hop_cnt_d = hop_cnt_q + 1'b1;
      end
    end
  end

  assign accept = trig_q && (state_q == S_IDLE) && fft_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  if (win_addr_q == LAST_K) state_d = S_FLUSH;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read addressing starts at wr_ptr after the triggering write, i.e. the oldest sample.
  always_comb begin
    rd_en_d         = 1'b0;
    rd_addr_d       = '0;
    win_addr_d      = '0;
    busy_d          = (state_d != S_IDLE);
    frame_start_d   = accept;
    frame_dropped_d = trig_q && !accept;
    frame_count_d   = accept ? frame_count_q + 16'd1 : frame_count_q;
    fft_in_valid_d  = rd_en_q;
    fft_in_last_d   = rd_en_q && (win_addr_q == LAST_K);
    if (state_d == S_READ) begin
      rd_en_d = 1'b1;
      if (accept) begin
        rd_addr_d  = wr_ptr_q;
        win_addr_d = '0;
      end else begin
        rd_addr_d  = rd_addr_q + 1'b1;
        win_addr_d = win_addr_q + 1'b1;
      end
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign win_addr      = win_addr_q;
  assign fft_in_valid  = fft_in_valid_q;
  assign fft_in_last   = fft_in_last_q;
  assign frame_start   = frame_start_q;
  assign frame_dropped = frame_dropped_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_stft_frame_sequencer.sv
// Bench for stft_frame_sequencer: two instances (HOP=4 and HOP=1, FFT_SIZE=8) share stimulus;
// an event-level model predicts every output each cycle, plus directed literal checks.
module tb_stft_frame_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned SW = 25;

  logic clk;
  logic RESET;
  logic start_compute;
  logic [SW-1:0] i_SAMPLE;
  logic fft_ready;

  logic          wr_en_a, rd_en_a, valid_a, last_a, fs_a, drop_a, busy_a;
  logic [AW-1:0] wr_addr_a, rd_addr_a, win_a;
  logic [SW-1:0] wr_data_a;
  logic [15:0]   fc_a;
  logic          wr_en_b, rd_en_b, valid_b, last_b, fs_b, drop_b, busy_b;
  logic [AW-1:0] wr_addr_b, rd_addr_b, win_b;
  logic [SW-1:0] wr_data_b;
  logic [15:0]   fc_b;

  stft_frame_sequencer #(.FFT_SIZE(N), .HOP(4), .AW(AW), .SW(SW)) dut_a (
    .clk(clk), .RESET(RESET), .start_compute(start_compute), .i_SAMPLE(i_SAMPLE),
    .fft_ready(fft_ready), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .win_addr(win_a), .fft_in_valid(valid_a),
    .fft_in_last(last_a), .frame_start(fs_a), .frame_dropped(drop_a), .busy(busy_a),
    .frame_count(fc_a));

  stft_frame_sequencer #(.FFT_SIZE(N), .HOP(1), .AW(AW), .SW(SW)) dut_b (
    .clk(clk), .RESET(RESET), .start_compute(start_compute), .i_SAMPLE(i_SAMPLE),
    .fft_ready(fft_ready), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .win_addr(win_b), .fft_in_valid(valid_b),
    .fft_in_last(last_b), .frame_start(fs_b), .frame_dropped(drop_b), .busy(busy_b),
    .frame_count(fc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Frame-level model: writes since reset, pending trigger, and the active frame's start cycle.
  typedef struct {
    int unsigned   writes;
    bit            pend;
    int unsigned   pend_base;
    bit            active;
    longint        t0;
    int unsigned   base;
    int unsigned   fcount;
    bit            drop;
    bit            wr_en;
    int unsigned   wr_addr;
    logic [SW-1:0] wr_data;
  } model_t;

  model_t      m [2];
  int unsigned hop_p [2] = '{4, 1};
  longint      cyc = 0;
  bit          chk_en = 1'b0;
  int          drop_b_cnt = 0;
  int          wr_b_cnt = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (RESET) begin
        m[i] = '{default: 0};
      end else begin
        bit prev_busy;
        prev_busy = m[i].active && ((cyc - 1 - m[i].t0) <= longint'(N));
        m[i].drop = 1'b0;
        if (m[i].pend) begin
          if (!prev_busy && fft_ready) begin
            m[i].active = 1'b1;
            m[i].t0     = cyc;
            m[i].base   = m[i].pend_base;
            m[i].fcount = (m[i].fcount + 1) % 65536;
          end else begin
            m[i].drop = 1'b1;
          end
        end
        m[i].pend  = 1'b0;
        m[i].wr_en = start_compute;
        if (start_compute) begin
          m[i].wr_addr = m[i].writes % N;
          m[i].wr_data = i_SAMPLE;
          m[i].writes++;
          if (m[i].writes >= N && (m[i].writes % hop_p[i]) == 0) begin
            m[i].pend      = 1'b1;
            m[i].pend_base = m[i].writes % N;
          end
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input logic we, input logic [AW-1:0] wa,
                          input logic [SW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                          input logic [AW-1:0] wi, input logic va, input logic la,
                          input logic fs, input logic dr, input logic bz, input logic [15:0] fc);
    longint d;
    bit act, e_rd;
    act  = m[i].active;
    d    = cyc - m[i].t0;
    e_rd = act && d >= 0 && d < longint'(N);
    chk($sformatf("wr_en_%0d", i), 32'(we), 32'(m[i].wr_en));
    if (m[i].wr_en) begin
      chk($sformatf("wr_addr_%0d", i), 32'(wa), m[i].wr_addr);
      chk($sformatf("wr_data_%0d", i), 32'(wd), 32'(m[i].wr_data));
    end
    chk($sformatf("rd_en_%0d", i), 32'(re), 32'(e_rd));
    if (e_rd) begin
      chk($sformatf("rd_addr_%0d", i), 32'(ra), 32'((longint'(m[i].base) + d) % N));
      chk($sformatf("win_addr_%0d", i), 32'(wi), 32'(d));
    end
    chk($sformatf("valid_%0d", i), 32'(va), 32'(act && d >= 1 && d <= longint'(N)));
    chk($sformatf("last_%0d", i), 32'(la), 32'(act && d == longint'(N)));
    chk($sformatf("frame_start_%0d", i), 32'(fs), 32'(act && d == 0));
    chk($sformatf("dropped_%0d", i), 32'(dr), 32'(m[i].drop));
    chk($sformatf("busy_%0d", i), 32'(bz), 32'(act && d <= longint'(N)));
    chk($sformatf("frame_count_%0d", i), 32'(fc), m[i].fcount);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, wr_en_a, wr_addr_a, wr_data_a, rd_en_a, rd_addr_a, win_a, valid_a, last_a,
               fs_a, drop_a, busy_a, fc_a);
      cmp_inst(1, wr_en_b, wr_addr_b, wr_data_b, rd_en_b, rd_addr_b, win_b, valid_b, last_b,
               fs_b, drop_b, busy_b, fc_b);
      if (drop_b) drop_b_cnt++;
      if (wr_en_b) wr_b_cnt++;
    end
  end

  int npulse = 0;

  // Stimulus runs 2 ns after each rising edge; pulse returns in the cycle after the write pulse.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input logic [SW-1:0] s);
    start_compute = 1'b1;
    i_SAMPLE      = s;
    @(posedge clk);
    #2;
    start_compute = 1'b0;
    npulse++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned seq2 [8] = '{4, 5, 6, 7, 0, 1, 2, 3};
    int d0, w0;
    bit found;
    RESET = 1'b1; start_compute = 1'b0; i_SAMPLE = '0; fft_ready = 1'b1;
    @(posedge clk); #2;
    chk_en = 1'b1;
    idle(1);
    chk("reset_rd_en", 32'(rd_en_a), 0);
    chk("reset_busy", 32'(busy_a), 0);
    chk("reset_wr_en", 32'(wr_en_a), 0);
    chk("reset_frame_count", 32'(fc_a), 0);
    RESET = 1'b0;
    idle(1);

    // T1: seven samples do not prime; the eighth starts a frame two cycles after its pulse.
    for (int i = 0; i < 7; i++) begin pulse(SW'(i)); idle(1); end
    chk("t1_no_frame", 32'(fc_a), 0);
    pulse(SW'(7));
    chk("t1_wr_en", 32'(wr_en_a), 1);
    chk("t1_rd_en_early", 32'(rd_en_a), 0);
    idle(1);
    chk("t1_frame_start", 32'(fs_a), 1);
    chk("t1_rd_addr0", 32'(rd_addr_a), 0);
    chk("t1_frame_count", 32'(fc_a), 1);
    idle(8);
    chk("t1_last", 32'(last_a), 1);
    chk("t1_busy_flush", 32'(busy_a), 1);
    idle(1);
    chk("t1_busy_done", 32'(busy_a), 0);
    idle(1);

    // T2: four more samples; frame reads oldest-first from slot 4.
    for (int i = 8; i < 12; i++) begin pulse(SW'(i)); idle(1); end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_rd_addr_k%0d", k), 32'(rd_addr_a), seq2[k]);
      idle(1);
    end
    chk("t2_last", 32'(last_a), 1);
    chk("t2_frame_count", 32'(fc_a), 2);
    idle(2);

    // T3: trigger with fft_ready low is dropped; the next hop frames normally.
    fft_ready = 1'b0;
    for (int i = 12; i < 16; i++) begin pulse(SW'(i)); if (i != 15) idle(1); end
    idle(1);
    chk("t3_dropped", 32'(drop_a), 1);
    chk("t3_no_rd", 32'(rd_en_a), 0);
    chk("t3_count_held", 32'(fc_a), 2);
    fft_ready = 1'b1;
    idle(1);
    for (int i = 16; i < 20; i++) begin pulse(SW'(i)); idle(1); end
    chk("t3_frame_start", 32'(fs_a), 1);
    chk("t3_frame_count", 32'(fc_a), 3);
    idle(10);

    // T4: pulses every three cycles; HOP=1 instance must drop triggers while busy.
    d0 = drop_b_cnt; w0 = wr_b_cnt;
    for (int i = 0; i < 10; i++) begin pulse(SW'(100 + i)); idle(2); end
    idle(12);
    chk("t4_drops_seen", 32'(drop_b_cnt > d0), 1);
    chk("t4_writes", 32'(wr_b_cnt - w0), 10);

    // T5: reset in the k=3 read cycle clears everything; seven pulses then give no frame.
    do begin
      pulse(SW'(200 + npulse));
      if (npulse % 4 != 0) idle(1);
    end while (npulse % 4 != 0);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      idle(1);
      if (fs_a) found = 1'b1;
    end
    chk("t5_frame_started", 32'(found), 1);
    idle(3);
    chk("t5_k3", 32'(win_a), 3);
    RESET = 1'b1;
    idle(1);
    chk("t5_rd_en", 32'(rd_en_a), 0);
    chk("t5_busy", 32'(busy_a), 0);
    chk("t5_valid", 32'(valid_a), 0);
    chk("t5_win", 32'(win_a), 0);
    chk("t5_count", 32'(fc_a), 0);
    RESET = 1'b0;
    npulse = 0;
    idle(1);
    for (int i = 0; i < 7; i++) begin pulse(SW'(300 + i)); idle(1); end
    idle(4);
    chk("t5_no_reprime", 32'(fc_a), 0);
    chk("t5_no_reprime_b", 32'(fc_b), 0);

    // T6: write data appears exactly one cycle after the pulse, for one cycle.
    pulse(25'h1ABCDEF);
    chk("t6_wr_en", 32'(wr_en_a), 1);
    chk("t6_wr_data", 32'(wr_data_a), 32'h1ABCDEF);
    chk("t6_wr_addr", 32'(wr_addr_a), 7);
    idle(1);
    chk("t6_wr_en_off", 32'(wr_en_a), 0);
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
